led_sequencer: RTL and testbench

Upstream control stage for `led_handler`. It turns raw DE1-SoC push-button presses into run/pause/clear commands and generates the paced one-cycle `enable` steps that advance the LED pattern. It drives the handler's active-low clear and counts completed pattern cycles from the handler's fed-back `stored_display`. It sits between the board keys/switches and `led_handler`.

---
 rtl/led_seq_pkg.sv | 24 ++
 rtl/led_sequencer_if.sv | 11 +
 rtl/led_sequencer_key_debouncer.sv | 71 +++++++
 rtl/led_sequencer.sv | 117 +++++++++++
 tb/tb_led_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared types, constants and the divider terminal helper for the LED sequencer.
package led_seq_pkg;

  localparam int unsigned LED_W  = 10;
  localparam int unsigned WRAP_W = 8;
  localparam int unsigned DIV_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CLEAR = 2'd3
  } seq_state_t;

  localparam logic [LED_W-1:0]  LED_ALL_ON = 10'b1111111111;
  localparam logic [WRAP_W-1:0] WRAP_MAX   = 8'd255;

  // Last divider count before a step; speed_sel halves the period per increment.
  function automatic logic [DIV_W-1:0] step_terminal(input logic [DIV_W-1:0] ticks,
                                                      input logic [1:0]       sel);
    return (ticks >> sel) - DIV_W'(1);
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Link between the sequencer (master) and led_handler (slave).
interface led_sequencer_if;
  import led_seq_pkg::*;

  logic             step_en;
  logic             handler_reset_n;
  logic [LED_W-1:0] led_state;

  modport master (output step_en, output handler_reset_n, input  led_state);
  modport slave  (input  step_en, input  handler_reset_n, output led_state);
endinterface

// File: rtl/led_sequencer_key_debouncer.sv
// Raw key -> 2-flop synchronizer -> optional stability filter -> one-cycle press pulse.
// The stability filter is compiled in only when LED_SEQ_DEBOUNCE_EN is defined.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic [1:0] sync_q, sync_d;
  logic       hist_q, hist_d;
  logic       press_q, press_d;
  logic       level_c;

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  // Accept the synchronized level only after it differs for DEBOUNCE_CYCLES straight cycles.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_q[1] != db_q) begin
      if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      db_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign level_c = db_q;
`else
  assign level_c = sync_q[1];
`endif

  always_comb begin
    sync_d  = {sync_q[0], key_n};
    hist_d  = level_c;
    press_d = hist_q & ~level_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      hist_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_sequencer.sv
// Run/pause/clear control and paced step generation for led_handler.
// Optional key debouncing is selected by the LED_SEQ_DEBOUNCE_EN macro.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICKS_PER_STEP  = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_run_n,
  input  logic              key_clear_n,
  input  logic [1:0]        speed_sel,
  led_sequencer_if.master   hif,
  output logic              running,
  output logic [WRAP_W-1:0] wrap_count
);

  logic run_press;
  logic clear_press;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
    .clk   (clk),
    .reset (reset),
    .key_n (key_run_n),
    .press (run_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
    .clk   (clk),
    .reset (reset),
    .key_n (key_clear_n),
    .press (clear_press)
  );

  seq_state_t        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              step_en_q, step_en_d;
  logic              running_q, running_d;
  logic              hrst_n_q, hrst_n_d;
  logic [DIV_W-1:0]  terminal_c;

  assign terminal_c = step_terminal(DIV_W'(TICKS_PER_STEP), speed_sel);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      wrap_q    <= '0;
      step_en_q <= 1'b0;
      running_q <= 1'b0;
      hrst_n_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      wrap_q    <= wrap_d;
      step_en_q <= step_en_d;
      running_q <= running_d;
      hrst_n_q  <= hrst_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    wrap_d    = wrap_q;
    step_en_d = 1'b0;

    // A step taken from the all-on pattern completes one pattern cycle.
    if (step_en_q && (hif.led_state == LED_ALL_ON) && (wrap_q != WRAP_MAX)) begin
      wrap_d = wrap_q + WRAP_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (run_press) state_d = RUN;
      end
      RUN: begin
        if (run_press) begin
          state_d = PAUSE;
        end else if (div_q >= terminal_c) begin
          step_en_d = 1'b1;
          div_d     = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      PAUSE: begin
        if (run_press) state_d = RUN;
      end
      CLEAR: begin
        state_d = IDLE;
        div_d   = '0;
        wrap_d  = '0;
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides everything, including a simultaneous run press.
    if (clear_press) begin
      state_d   = CLEAR;
      div_d     = '0;
      wrap_d    = '0;
      step_en_d = 1'b0;
    end

    running_d = (state_d == RUN);
    hrst_n_d  = (state_d == RUN) || (state_d == PAUSE);
  end

  assign hif.step_en         = step_en_q;
  assign hif.handler_reset_n = hrst_n_q;
  assign running             = running_q;
  assign wrap_count          = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized bench for led_sequencer against a cycle-level behavioural model.
module tb_led_sequencer;

  localparam int unsigned TPS = 16;
  localparam int unsigned DEB = 4;
`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int unsigned RUNLEN  = DEB;
  localparam int unsigned EVT_DLY = 4;
`else
  localparam int unsigned RUNLEN  = 1;
  localparam int unsigned EVT_DLY = 3;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_CLEAR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_run_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic [1:0] speed_sel = 2'd0;
  logic       running;
  logic [7:0] wrap_count;

  led_sequencer_if hif();

  led_sequencer #(.TICKS_PER_STEP(TPS), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_run_n   (key_run_n),
    .key_clear_n (key_clear_n),
    .speed_sel   (speed_sel),
    .hif         (hif),
    .running     (running),
    .wrap_count  (wrap_count)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int          m_state = M_IDLE;
  int unsigned m_div   = 0;
  bit          m_step  = 1'b0;
  int          m_wrap  = 0;
  bit          m_lvl[2];
  int          m_runlen[2];
  bit          ev_ring[2][8];
  int unsigned m_cyc = 0;

  always @(posedge clk) begin
    bit          raw_k[2];
    bit          ev_run, ev_clr, prev_step;
    int unsigned term;
    int          slot;
    if (reset) begin
      m_state = M_IDLE; m_div = 0; m_step = 1'b0; m_wrap = 0;
      for (int k = 0; k < 2; k++) begin
        m_lvl[k] = 1'b1; m_runlen[k] = 0;
        for (int s = 0; s < 8; s++) ev_ring[k][s] = 1'b0;
      end
    end else begin
      raw_k[0] = key_run_n;
      raw_k[1] = key_clear_n;
      // A key level is believed once it has held for RUNLEN samples; a fall to 0 is a press.
      for (int k = 0; k < 2; k++) begin
        if (raw_k[k] != m_lvl[k]) begin
          m_runlen[k]++;
          if (m_runlen[k] >= int'(RUNLEN)) begin
            m_lvl[k]    = raw_k[k];
            m_runlen[k] = 0;
            if (!raw_k[k]) ev_ring[k][int'((m_cyc + EVT_DLY) % 8)] = 1'b1;
          end
        end else begin
          m_runlen[k] = 0;
        end
      end
      slot   = int'(m_cyc % 8);
      ev_run = ev_ring[0][slot];
      ev_clr = ev_ring[1][slot];
      ev_ring[0][slot] = 1'b0;
      ev_ring[1][slot] = 1'b0;

      term      = (TPS >> speed_sel) - 1;
      prev_step = m_step;
      m_step    = 1'b0;
      if (prev_step && hif.led_state == 10'h3FF && m_wrap < 255) m_wrap++;
      if (ev_clr) begin
        m_state = M_CLEAR; m_div = 0; m_wrap = 0;
      end else if (m_state == M_CLEAR) begin
        m_state = M_IDLE; m_div = 0; m_wrap = 0;
      end else if (m_state == M_RUN) begin
        if (ev_run) m_state = M_PAUSE;
        else if (m_div >= term) begin m_step = 1'b1; m_div = 0; end
        else m_div++;
      end else if (ev_run) begin
        m_state = M_RUN;
      end
    end
    m_cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("step_en", 32'(hif.step_en), 32'(m_step));
      check_eq("running", 32'(running), 32'(m_state == M_RUN));
      check_eq("handler_reset_n", 32'(hif.handler_reset_n),
               32'(m_state == M_RUN || m_state == M_PAUSE));
      check_eq("wrap_count", 32'(wrap_count), 32'(m_wrap));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 run, 1 clear, 2 both
  task automatic press_key(input int which, input int len, input int gap);
    @(negedge clk);
    if (which != 1) key_run_n = 1'b0;
    if (which != 0) key_clear_n = 1'b0;
    repeat (len) @(negedge clk);
    key_run_n   = 1'b1;
    key_clear_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  steps_seen;
    bit  reached;
    hif.led_state = '0;
    @(posedge clk);
    chk_en = 1'b1;

    // 1: reset for 3 cycles, then idle with no steps
    idle(3);
    reset = 1'b0;
    steps_seen = 0;
    repeat (100) begin
      @(negedge clk);
      steps_seen += int'(hif.step_en);
    end
    check_eq("t1_no_steps_idle", 32'(steps_seen), 32'd0);
    check_eq("t1_hrst_n_idle", 32'(hif.handler_reset_n), 32'd0);

    // 2: run press, base rate
    speed_sel = 2'd0;
    press_key(0, 10, 70);
    check_eq("t2_running", 32'(running), 32'd1);

    // 3: bounce then a clean press
    press_key(0, 2, 0);
    press_key(0, 1, 0);
    key_run_n = 1'b1;
    idle(1);
    press_key(0, 2, 20);
    press_key(0, 6, 20);
    if (m_state != M_RUN) press_key(0, 6, 20);
    check_eq("t3_back_running", 32'(running), 32'd1);

    // 4: speed change at count 10, then pause and resume
    speed_sel = 2'd0;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (m_state == M_RUN && m_div == 10) reached = 1'b1;
      else @(negedge clk);
    end
    check_eq("t4_reach_count10", 32'(reached), 32'd1);
    speed_sel = 2'd2;
    @(negedge clk);
    check_eq("t4_step_after_speedup", 32'(hif.step_en), 32'd1);
    idle(20);
    press_key(0, 6, 10);
    steps_seen = 0;
    repeat (50) begin
      @(negedge clk);
      steps_seen += int'(hif.step_en);
    end
    check_eq("t4_no_steps_paused", 32'(steps_seen), 32'd0);
    press_key(0, 6, 30);

    // 5: wrap counter saturation
    if (m_state != M_RUN) press_key(0, 6, 10);
    speed_sel = 2'd3;
    hif.led_state = 10'h3FF;
    idle(660);
    check_eq("t5_wrap_saturated", 32'(wrap_count), 32'd255);
    hif.led_state = '0;

    // 6: clear and run in the same cycle
    press_key(2, 6, 12);
    check_eq("t6_running", 32'(running), 32'd0);
    check_eq("t6_hrst_n", 32'(hif.handler_reset_n), 32'd0);
    check_eq("t6_wrap_cleared", 32'(wrap_count), 32'd0);

    // Random traffic, including resets mid-count and mid-debounce
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: press_key(0, int'($urandom_range(1, 8)), int'($urandom_range(1, 12)));
        4:          press_key(1, int'($urandom_range(1, 8)), int'($urandom_range(1, 12)));
        5:          begin @(negedge clk); speed_sel = 2'($urandom_range(0, 3)); end
        6:          begin
                      @(negedge clk);
                      hif.led_state = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
                    end
        7:          press_key(2, int'($urandom_range(1, 8)), int'($urandom_range(1, 12)));
        8:          begin
                      @(negedge clk);
                      if ($urandom_range(0, 1) == 1) key_run_n = 1'b0;
                      reset = 1'b1;
                      idle(int'($urandom_range(1, 2)));
                      reset = 1'b0;
                      idle(int'($urandom_range(0, 6)));
                      key_run_n = 1'b1;
                    end
        default:    idle(int'($urandom_range(1, 40)));
      endcase
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
